// File: rtl/fetch_control.sv
// Fetch control FSM: drives PC enable/load, instruction squash and
// interrupt entry from branch, stall, interrupt and halt requests.
//
// Ports:
//   i_clk, i_reset           rising-edge clock, synchronous active-high reset
//   i_stall_req              load-use hazard, hold fetch
//   i_branch_taken           redirect request
//   i_branch_target[15:0]    redirect address
//   i_int_req                external interrupt level (rising edge detected)
//   i_int_vector[15:0]       handler address, captured at acceptance
//   i_halt_req               HLT decoded
//   o_pc_enable              PC advances
//   o_pc_write               PC loaded with o_pc_write_back_value
//   o_pc_write_back_value    load value, zero whenever o_pc_write is low
//   o_clear_instruction      squash the instruction in fetch
//   o_int_ack                one-cycle pulse on handler jump
//   o_halted                 core halted
module fetch_control #(
   parameter logic [15:0] RESET_VECTOR = 16'h0020
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall_req,
   input  logic        i_branch_taken,
   input  logic [15:0] i_branch_target,
   input  logic        i_int_req,
   input  logic [15:0] i_int_vector,
   input  logic        i_halt_req,
   output logic        o_pc_enable,
   output logic        o_pc_write,
   output logic [15:0] o_pc_write_back_value,
   output logic        o_clear_instruction,
   output logic        o_int_ack,
   output logic        o_halted
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_RUN,
      S_STALL,
      S_FLUSH,
      S_INT_DRAIN,
      S_INT_JUMP,
      S_HALTED
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_int_prev;
   logic        r_pending;
   logic [15:0] r_redirect;
   logic [15:0] r_vector;
   logic [1:0]  r_drain_cnt;

   logic        w_int_edge;
   logic        w_pending;
   logic        w_capture_branch;
   logic        w_accept_int;

   assign w_int_edge = i_int_req & ~r_int_prev;
   // An edge seen this cycle counts as pending so it can win
   // against a simultaneous stall request.
   assign w_pending  = r_pending | w_int_edge;

   always_comb begin
      w_next           = r_state;
      w_capture_branch = 1'b0;
      w_accept_int     = 1'b0;
      unique case (r_state)
         S_BOOT: w_next = S_RUN;
         S_RUN: begin
            if (i_branch_taken) begin
               w_next           = S_FLUSH;
               w_capture_branch = 1'b1;
            end else if (w_pending) begin
               w_next       = S_INT_DRAIN;
               w_accept_int = 1'b1;
            end else if (i_stall_req) begin
               w_next = S_STALL;
            end else if (i_halt_req) begin
               w_next = S_HALTED;
            end
         end
         S_STALL: begin
            if (i_branch_taken) begin
               w_next           = S_FLUSH;
               w_capture_branch = 1'b1;
            end else if (!i_stall_req) begin
               w_next = S_RUN;
            end
         end
         S_FLUSH: w_next = S_RUN;
         S_INT_DRAIN: begin
            if (r_drain_cnt == 2'd1) begin
               w_next = S_INT_JUMP;
            end
         end
         S_INT_JUMP: w_next = S_RUN;
         S_HALTED: begin
            if (w_pending) begin
               w_next       = S_INT_DRAIN;
               w_accept_int = 1'b1;
            end
         end
         default: w_next = S_BOOT;
      endcase
   end

   always_comb begin
      o_pc_enable           = 1'b0;
      o_pc_write            = 1'b0;
      o_pc_write_back_value = 16'h0000;
      o_clear_instruction   = 1'b0;
      o_int_ack             = 1'b0;
      o_halted              = 1'b0;
      unique case (r_state)
         S_BOOT: begin
            o_pc_write            = 1'b1;
            o_pc_write_back_value = RESET_VECTOR;
            o_clear_instruction   = 1'b1;
         end
         S_RUN: o_pc_enable = 1'b1;
         S_STALL: ;
         S_FLUSH: begin
            o_pc_enable           = 1'b1;
            o_pc_write            = 1'b1;
            o_pc_write_back_value = r_redirect;
            o_clear_instruction   = 1'b1;
         end
         S_INT_DRAIN: o_clear_instruction = 1'b1;
         S_INT_JUMP: begin
            o_pc_enable           = 1'b1;
            o_pc_write            = 1'b1;
            o_pc_write_back_value = r_vector;
            o_clear_instruction   = 1'b1;
            o_int_ack             = 1'b1;
         end
         S_HALTED: begin
            o_clear_instruction = 1'b1;
            o_halted            = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_BOOT;
         // Level already high at release must not look like an edge.
         r_int_prev  <= 1'b1;
         r_pending   <= 1'b0;
         r_redirect  <= 16'h0000;
         r_vector    <= 16'h0000;
         r_drain_cnt <= 2'd0;
      end else begin
         r_state    <= w_next;
         r_int_prev <= i_int_req;
         if (w_capture_branch) begin
            r_redirect <= i_branch_target;
         end
         if (w_accept_int) begin
            r_vector <= i_int_vector;
         end
         if (r_state == S_INT_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
         end else begin
            r_drain_cnt <= 2'd0;
         end
         // Clear wins over a new edge: edges while pending are dropped.
         if (r_state == S_INT_JUMP) begin
            r_pending <= 1'b0;
         end else if (w_int_edge) begin
            r_pending <= 1'b1;
         end
      end
   end

endmodule
